// File: rtl/i2c_slave_ctrl_if.sv
// Pad and local-side signal bundle for the I2C target byte engine.
// The slave modport faces the engine; master faces pads and front end.
interface i2c_slave_ctrl_if;
   logic [6:0] slave_addr_i;
   logic       scl_pad_i;
   logic       scl_pad_o;
   logic       scl_padoen_o;
   logic       sda_pad_i;
   logic       sda_pad_o;
   logic       sda_padoen_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       nack_i;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic       start_o;
   logic       stop_o;
   logic       addressed_o;
   logic       read_mode_o;

   modport slave (
      input  slave_addr_i, scl_pad_i, sda_pad_i,
      input  nack_i, tx_data_i, tx_valid_i,
      output scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o,
      output rx_data_o, rx_valid_o, tx_ready_o,
      output start_o, stop_o, addressed_o, read_mode_o
   );

   modport master (
      output slave_addr_i, scl_pad_i, sda_pad_i,
      output nack_i, tx_data_i, tx_valid_i,
      input  scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o,
      input  rx_data_o, rx_valid_o, tx_ready_o,
      input  start_o, stop_o, addressed_o, read_mode_o
   );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C target byte engine: START/STOP detect, 7-bit address match,
// ACK generation, byte receive/transmit and SCL stretching.
module i2c_slave_ctrl #(
   parameter int SYNC_STAGES   = 2,
   parameter int STRETCH_SETUP = 4
) (
   input logic             HCLK,
   input logic             HRESET,
   i2c_slave_ctrl_if.slave bus
);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] ADDR      = 4'd1;
   localparam logic [3:0] ADDR_ACK  = 4'd2;
   localparam logic [3:0] RX_BYTE   = 4'd3;
   localparam logic [3:0] RX_ACK    = 4'd4;
   localparam logic [3:0] TX_LOAD   = 4'd5;
   localparam logic [3:0] TX_BYTE   = 4'd6;
   localparam logic [3:0] TX_ACKCHK = 4'd7;
   localparam logic [3:0] WAIT_STOP = 4'd8;

   localparam logic [7:0] SETUP_M1 = 8'(STRETCH_SETUP - 1);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic       scl_prev;
   logic       sda_prev;
   logic       scl_cur;
   logic       sda_cur;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;

   logic [3:0] state;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] setup_cnt;
   logic       phase;
   logic       scl_oen;
   logic       sda_oen;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_ready;
   logic       start_p;
   logic       stop_p;
   logic       addressed;
   logic       read_mode;

   assign scl_cur   = scl_sync[SYNC_STAGES-1];
   assign sda_cur   = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_cur & ~scl_prev;
   assign scl_fall  = ~scl_cur & scl_prev;
   assign start_det = scl_cur & scl_prev & sda_prev & ~sda_cur;
   assign stop_det  = scl_cur & scl_prev & ~sda_prev & sda_cur;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         scl_sync  <= '1;
         sda_sync  <= '1;
         scl_prev  <= 1'b1;
         sda_prev  <= 1'b1;
         state     <= IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 8'd0;
         setup_cnt <= 8'd0;
         phase     <= 1'b0;
         scl_oen   <= 1'b1;
         sda_oen   <= 1'b1;
         rx_data   <= 8'd0;
         rx_valid  <= 1'b0;
         tx_ready  <= 1'b0;
         start_p   <= 1'b0;
         stop_p    <= 1'b0;
         addressed <= 1'b0;
         read_mode <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_pad_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_pad_i};
         scl_prev <= scl_cur;
         sda_prev <= sda_cur;
         rx_valid <= 1'b0;
         tx_ready <= 1'b0;
         start_p  <= 1'b0;
         stop_p   <= 1'b0;
         if (start_det) begin
            state     <= ADDR;
            bit_cnt   <= 4'd0;
            phase     <= 1'b0;
            start_p   <= 1'b1;
            addressed <= 1'b0;
            scl_oen   <= 1'b1;
            sda_oen   <= 1'b1;
         end else if (stop_det) begin
            state     <= IDLE;
            phase     <= 1'b0;
            stop_p    <= 1'b1;
            addressed <= 1'b0;
            scl_oen   <= 1'b1;
            sda_oen   <= 1'b1;
         end else begin
            case (state)
               ADDR: if (scl_rise) begin
                  shreg   <= {shreg[6:0], sda_cur};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     if (shreg[6:0] == bus.slave_addr_i) begin
                        state     <= ADDR_ACK;
                        phase     <= 1'b0;
                        addressed <= 1'b1;
                        read_mode <= sda_cur;
                     end else begin
                        state <= WAIT_STOP;
                     end
                  end
               end
               // phase 0: drive ACK at the next fall; phase 1: release it
               ADDR_ACK, RX_ACK: if (scl_fall) begin
                  if (!phase) begin
                     sda_oen <= 1'b0;
                     phase   <= 1'b1;
                  end else begin
                     sda_oen <= 1'b1;
                     phase   <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= (state == ADDR_ACK && read_mode) ?
                                TX_LOAD : RX_BYTE;
                  end
               end
               RX_BYTE: if (scl_rise) begin
                  shreg   <= {shreg[6:0], sda_cur};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     rx_data  <= {shreg[6:0], sda_cur};
                     rx_valid <= 1'b1;
                     phase    <= 1'b0;
                     state    <= bus.nack_i ? WAIT_STOP : RX_ACK;
                  end
               end
               // entered just after an SCL fall; phase 1 = setup countdown
               TX_LOAD: begin
                  if (!phase) begin
                     if (bus.tx_valid_i) begin
                        shreg    <= bus.tx_data_i;
                        sda_oen  <= bus.tx_data_i[7];
                        tx_ready <= 1'b1;
                        bit_cnt  <= 4'd1;
                        if (scl_oen) begin
                           state <= TX_BYTE;
                        end else begin
                           phase     <= 1'b1;
                           setup_cnt <= SETUP_M1;
                        end
                     end else begin
                        scl_oen <= 1'b0;
                     end
                  end else if (setup_cnt == 8'd0) begin
                     scl_oen <= 1'b1;
                     phase   <= 1'b0;
                     state   <= TX_BYTE;
                  end else begin
                     setup_cnt <= setup_cnt - 8'd1;
                  end
               end
               TX_BYTE: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oen <= 1'b1;
                     phase   <= 1'b0;
                     state   <= TX_ACKCHK;
                  end else begin
                     sda_oen <= shreg[6];
                     shreg   <= {shreg[6:0], 1'b0};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               TX_ACKCHK: begin
                  if (scl_rise) begin
                     if (sda_cur) state <= WAIT_STOP;
                     else         phase <= 1'b1;
                  end else if (scl_fall && phase) begin
                     phase <= 1'b0;
                     state <= TX_LOAD;
                  end
               end
               IDLE, WAIT_STOP: begin
                  scl_oen <= 1'b1;
                  sda_oen <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.scl_pad_o    = 1'b0;
   assign bus.sda_pad_o    = 1'b0;
   assign bus.scl_padoen_o = scl_oen;
   assign bus.sda_padoen_o = sda_oen;
   assign bus.rx_data_o    = rx_data;
   assign bus.rx_valid_o   = rx_valid;
   assign bus.tx_ready_o   = tx_ready;
   assign bus.start_o      = start_p;
   assign bus.stop_o       = stop_p;
   assign bus.addressed_o  = addressed;
   assign bus.read_mode_o  = read_mode;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench: a behavioural I2C master on a wired-AND bus drives
// the target through write, read, stretch, NACK and reset scenarios.
module tb_i2c_slave_ctrl;
   localparam int Q     = 8;
   localparam int SETUP = 4;

   logic HCLK   = 1'b0;
   logic HRESET = 1'b1;
   logic m_scl  = 1'b1;
   logic m_sda  = 1'b1;

   always #5 HCLK = ~HCLK;

   i2c_slave_ctrl_if bus ();

   assign bus.scl_pad_i = m_scl & bus.scl_padoen_o;
   assign bus.sda_pad_i = m_sda & bus.sda_padoen_o;

   i2c_slave_ctrl #(
      .SYNC_STAGES  (2),
      .STRETCH_SETUP(SETUP)
   ) dut (
      .HCLK  (HCLK),
      .HRESET(HRESET),
      .bus   (bus.slave)
   );

   int vectors = 0;
   int errs    = 0;

   int         rx_cnt = 0, tx_cnt = 0, start_cnt = 0, stop_cnt = 0;
   logic [7:0] rx_last = 8'd0;
   int         low_run = 0, last_low = 0;
   int         sda_run = 0, setup_seen = 0;
   int         since_tx = 0, tx_to_rel = 0;
   logic       prev_scl_oen = 1'b1, prev_sda_oen = 1'b1;

   always @(negedge HCLK) begin
      if (bus.rx_valid_o) begin
         rx_cnt++;
         rx_last = bus.rx_data_o;
      end
      if (bus.tx_ready_o) begin
         tx_cnt++;
         since_tx = 0;
      end else begin
         since_tx++;
      end
      if (bus.start_o) start_cnt++;
      if (bus.stop_o)  stop_cnt++;
      if (bus.sda_padoen_o != prev_sda_oen) sda_run = 1;
      else                                  sda_run++;
      if (!bus.scl_padoen_o) begin
         low_run++;
      end else begin
         if (!prev_scl_oen) begin
            last_low   = low_run;
            setup_seen = sda_run - 1;
            tx_to_rel  = since_tx;
         end
         low_run = 0;
      end
      prev_scl_oen = bus.scl_padoen_o;
      prev_sda_oen = bus.sda_padoen_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic scl_high();
      int k;
      k = 0;
      m_scl = 1'b1;
      while (!bus.scl_pad_i && k < 1000) begin
         cyc(1);
         k++;
      end
      chk("scl_released", 32'(bus.scl_pad_i), 32'd1);
   endtask

   task automatic write_bit(input logic b);
      m_sda = b;
      cyc(Q);
      scl_high();
      cyc(2 * Q);
      m_scl = 1'b0;
      cyc(Q);
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1;
      cyc(Q);
      scl_high();
      cyc(Q);
      b = bus.sda_pad_i;
      cyc(Q);
      m_scl = 1'b0;
      cyc(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
   endtask

   task automatic start_c();
      m_sda = 1'b1;
      cyc(Q);
      m_scl = 1'b1;
      cyc(2 * Q);
      m_sda = 1'b0;
      cyc(2 * Q);
      m_scl = 1'b0;
      cyc(Q);
   endtask

   task automatic stop_c();
      m_sda = 1'b0;
      cyc(Q);
      m_scl = 1'b1;
      cyc(2 * Q);
      m_sda = 1'b1;
      cyc(2 * Q);
   endtask

   initial begin
      logic       ack;
      logic       b;
      logic [7:0] d;
      int         sc;
      int         k;

      bus.slave_addr_i = 7'h50;
      bus.nack_i       = 1'b0;
      bus.tx_data_i    = 8'h00;
      bus.tx_valid_i   = 1'b0;
      cyc(5);
      chk("rst_scl_oen", 32'(bus.scl_padoen_o), 32'd1);
      chk("rst_sda_oen", 32'(bus.sda_padoen_o), 32'd1);
      chk("rst_rx_data", 32'(bus.rx_data_o), 32'h00);
      chk("rst_addressed", 32'(bus.addressed_o), 32'd0);
      chk("rst_read_mode", 32'(bus.read_mode_o), 32'd0);
      chk("rst_pulses", 32'({bus.start_o, bus.stop_o,
                             bus.rx_valid_o, bus.tx_ready_o}), 32'd0);
      HRESET = 1'b0;
      cyc(5);

      // master write 0x50: 0xA5, 0x3C
      start_c();
      chk("w_start_cnt", 32'(start_cnt), 32'd1);
      write_byte(8'hA0, ack);
      chk("w_addr_ack", 32'(ack), 32'd0);
      chk("w_addressed", 32'(bus.addressed_o), 32'd1);
      chk("w_read_mode", 32'(bus.read_mode_o), 32'd0);
      write_byte(8'hA5, ack);
      chk("w_d0_ack", 32'(ack), 32'd0);
      chk("w_d0_cnt", 32'(rx_cnt), 32'd1);
      chk("w_d0_data", 32'(rx_last), 32'hA5);
      write_byte(8'h3C, ack);
      chk("w_d1_ack", 32'(ack), 32'd0);
      chk("w_d1_cnt", 32'(rx_cnt), 32'd2);
      chk("w_d1_data", 32'(rx_last), 32'h3C);
      stop_c();
      chk("w_stop_cnt", 32'(stop_cnt), 32'd1);
      chk("w_addr_drop", 32'(bus.addressed_o), 32'd0);

      // wrong address 0x51
      start_c();
      write_byte(8'hA2, ack);
      chk("mis_addr_nack", 32'(ack), 32'd1);
      chk("mis_addressed", 32'(bus.addressed_o), 32'd0);
      write_byte(8'h11, ack);
      chk("mis_data_nack", 32'(ack), 32'd1);
      chk("mis_rx_cnt", 32'(rx_cnt), 32'd2);
      stop_c();
      chk("mis_stop_cnt", 32'(stop_cnt), 32'd2);

      // master read: 0xC3 ACKed, 0x5A NACKed
      bus.tx_data_i  = 8'hC3;
      bus.tx_valid_i = 1'b1;
      start_c();
      write_byte(8'hA1, ack);
      chk("r_addr_ack", 32'(ack), 32'd0);
      chk("r_read_mode", 32'(bus.read_mode_o), 32'd1);
      chk("r_tx_cnt0", 32'(tx_cnt), 32'd1);
      bus.tx_data_i = 8'h5A;
      read_byte(d);
      chk("r_byte0", 32'(d), 32'hC3);
      write_bit(1'b0);
      read_byte(d);
      chk("r_byte1", 32'(d), 32'h5A);
      chk("r_tx_cnt1", 32'(tx_cnt), 32'd2);
      write_bit(1'b1);
      read_bit(b);
      chk("r_after_nack_sda", 32'(b), 32'd1);
      chk("r_after_nack_cnt", 32'(tx_cnt), 32'd2);
      bus.tx_valid_i = 1'b0;
      stop_c();

      // read with tx data late: stretch
      bus.tx_data_i = 8'h6B;
      start_c();
      write_byte(8'hA1, ack);
      chk("s_addr_ack", 32'(ack), 32'd0);
      k = 0;
      while (low_run < 49 && k < 500) begin
         cyc(1);
         k++;
      end
      chk("s_stretch_on", 32'(bus.scl_padoen_o), 32'd0);
      // controller samples tx_valid_i high after 50 low samples
      bus.tx_valid_i = 1'b1;
      read_byte(d);
      bus.tx_valid_i = 1'b0;
      chk("s_byte", 32'(d), 32'h6B);
      chk("s_hold_cycles", 32'(last_low), 32'(50 + SETUP));
      chk("s_sda_setup_ok", 32'(setup_seen >= SETUP), 32'd1);
      chk("s_rel_after_load", 32'(tx_to_rel), 32'(SETUP));
      chk("s_tx_cnt", 32'(tx_cnt), 32'd3);
      write_bit(1'b1);
      stop_c();

      // nack_i on received byte, then repeated START mid-address
      start_c();
      write_byte(8'hA0, ack);
      chk("n_addr_ack", 32'(ack), 32'd0);
      bus.nack_i = 1'b1;
      write_byte(8'h96, ack);
      bus.nack_i = 1'b0;
      chk("n_data_nack", 32'(ack), 32'd1);
      chk("n_rx_data", 32'(rx_last), 32'h96);
      chk("n_rx_cnt", 32'(rx_cnt), 32'd3);
      sc = start_cnt;
      start_c();
      write_bit(1'b1);
      write_bit(1'b0);
      write_bit(1'b1);
      start_c();
      chk("rs_start_cnt", 32'(start_cnt), 32'(sc + 2));
      write_byte(8'hA0, ack);
      chk("rs_addr_ack", 32'(ack), 32'd0);
      write_byte(8'h01, ack);
      chk("rs_data_ack", 32'(ack), 32'd0);
      chk("rs_rx_data", 32'(rx_last), 32'h01);

      // reset while the ACK is being driven
      for (int i = 7; i >= 0; i--) write_bit(1'b1);
      chk("ra_ack_driven", 32'(bus.sda_padoen_o), 32'd0);
      HRESET = 1'b1;
      cyc(1);
      chk("ra_sda_oen", 32'(bus.sda_padoen_o), 32'd1);
      chk("ra_scl_oen", 32'(bus.scl_padoen_o), 32'd1);
      chk("ra_addressed", 32'(bus.addressed_o), 32'd0);
      chk("ra_rx_data", 32'(bus.rx_data_o), 32'h00);
      HRESET = 1'b0;
      cyc(2);
      stop_c();

      // reset while SCL is stretched
      start_c();
      write_byte(8'hA1, ack);
      chk("rs2_addr_ack", 32'(ack), 32'd0);
      cyc(3);
      chk("rs2_stretching", 32'(bus.scl_padoen_o), 32'd0);
      HRESET = 1'b1;
      cyc(1);
      chk("rs2_scl_oen", 32'(bus.scl_padoen_o), 32'd1);
      chk("rs2_sda_oen", 32'(bus.sda_padoen_o), 32'd1);
      chk("rs2_read_mode", 32'(bus.read_mode_o), 32'd0);
      chk("rs2_addressed", 32'(bus.addressed_o), 32'd0);
      HRESET = 1'b0;
      cyc(2);
      stop_c();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
